sort_10_gather: RTL and testbench

- Upstream feeder for the 10-input, 32-bit combinational sorting network.
- Accepts a serial valid/ready stream of words and packs up to 10 of them into a frame of registered slots. The slots drive the sorter's data_0..data_9 inputs directly.
- Short frames, terminated by in_last, are padded with PAD_VALUE so padding sorts to the top positions.
- Presents each complete frame with out_valid/out_ready and holds it stable until accepted.

---
 rtl/sort_10_gather.sv | 117 +++++++++++
 tb/tb_sort_10_gather.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sort_10_gather.sv
// Packs a valid/ready word stream into ten registered slots that feed the
// 10-input sorting network; short frames are padded so padding sorts high.
//
//   state | meaning
//   FILL  | accepting words into slot idx
//   HOLD  | complete frame presented on data_0..data_9, waiting for out_ready
module sort_10_gather #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] PAD_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_count,
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic [WIDTH-1:0] data_2,
  output logic [WIDTH-1:0] data_3,
  output logic [WIDTH-1:0] data_4,
  output logic [WIDTH-1:0] data_5,
  output logic [WIDTH-1:0] data_6,
  output logic [WIDTH-1:0] data_7,
  output logic [WIDTH-1:0] data_8,
  output logic [WIDTH-1:0] data_9
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd9;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       count_q, count_d;
  logic [WIDTH-1:0] slot_q [10];
  logic [WIDTH-1:0] slot_d [10];
  logic             accept;
  logic             closing;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    slot_d  = slot_q;
    accept  = in_valid && (state_q == FILL);
    closing = in_last || (idx_q == LAST_IDX);

    case (state_q)
      FILL: begin
        if (accept) begin
          // The closing word and its padding land in the same cycle.
          for (int k = 0; k < 10; k++) begin
            if (4'(k) == idx_q) begin
              slot_d[k] = in_data;
            end else if (closing && (4'(k) > idx_q)) begin
              slot_d[k] = PAD_VALUE;
            end
          end
          if (closing) begin
            count_d = idx_q + 4'd1;
            idx_d   = 4'd0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= 4'd0;
      count_q <= 4'd0;
      for (int k = 0; k < 10; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      for (int k = 0; k < 10; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_count = count_q;

  assign data_0 = slot_q[0];
  assign data_1 = slot_q[1];
  assign data_2 = slot_q[2];
  assign data_3 = slot_q[3];
  assign data_4 = slot_q[4];
  assign data_5 = slot_q[5];
  assign data_6 = slot_q[6];
  assign data_7 = slot_q[7];
  assign data_8 = slot_q[8];
  assign data_9 = slot_q[9];

endmodule

// File: tb/tb_sort_10_gather.sv
// Directed bench for sort_10_gather: full, short, single-word, backpressured,
// reset-interrupted and back-to-back frames with hand-computed slot values.
module tb_sort_10_gather;

  localparam logic [31:0] PAD = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_count;
  logic [31:0] d [10];

  int vectors = 0;
  int errors  = 0;

  sort_10_gather dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .data_0    (d[0]),
    .data_1    (d[1]),
    .data_2    (d[2]),
    .data_3    (d[3]),
    .data_4    (d[4]),
    .data_5    (d[5]),
    .data_6    (d[6]),
    .data_7    (d[7]),
    .data_8    (d[8]),
    .data_9    (d[9])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] word, input logic last);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (n == 100) check("send_wait_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = word;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  logic [31:0] w [30];
  int          ptr;
  int          frames;
  int          zero_cycles;
  int          cycles;
  logic        prev_ready;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_count", {28'd0, out_count}, 32'd0);
    check("rst_data_0", d[0], 32'd0);
    check("rst_data_9", d[9], 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // Full frame, in_valid held high across all ten words.
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'(10 - i);
      step();
      if (i == 8) check("full_not_yet_valid", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_out_count", {28'd0, out_count}, 32'd10);
    for (int k = 0; k < 10; k++) check($sformatf("full_data_%0d", k), d[k], 32'(10 - k));
    handshake();

    // Short frame with padding.
    send(32'h30, 1'b0);
    send(32'h10, 1'b0);
    send(32'h20, 1'b1);
    check("short_out_valid", {31'd0, out_valid}, 32'd1);
    check("short_out_count", {28'd0, out_count}, 32'd3);
    check("short_data_0", d[0], 32'h30);
    check("short_data_1", d[1], 32'h10);
    check("short_data_2", d[2], 32'h20);
    for (int k = 3; k < 10; k++) check($sformatf("short_pad_%0d", k), d[k], PAD);

    // Backpressure: frame held while a word waits upstream.
    in_valid = 1'b1;
    in_data  = 32'h55;
    in_last  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data_0", d[0], 32'h30);
      check("bp_data_9", d[9], PAD);
      check("bp_out_count", {28'd0, out_count}, 32'd3);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_hs_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_hs_data_0_kept", d[0], 32'h30);
    step();
    in_valid = 1'b0;
    check("bp_accept_data_0", d[0], 32'h55);
    check("bp_stale_data_1", d[1], 32'h10);
    check("bp_accept_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset between edges with four words in the frame.
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    send(32'h3, 1'b0);
    check("mid_data_3", d[3], 32'h3);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data_0", d[0], 32'd0);
    check("mid_rst_data_3", d[3], 32'd0);
    check("mid_rst_data_9", d[9], 32'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) send(32'h100 + 32'(i), 1'b0);
    check("fresh_out_valid", {31'd0, out_valid}, 32'd1);
    check("fresh_out_count", {28'd0, out_count}, 32'd10);
    for (int k = 0; k < 10; k++) check($sformatf("fresh_data_%0d", k), d[k], 32'h100 + 32'(k));

    // Reset while a frame is presented.
    #3;
    rst_n = 1'b0;
    #1;
    check("hold_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("hold_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("hold_rst_out_count", {28'd0, out_count}, 32'd0);
    #1;
    rst_n = 1'b1;

    // Single-word frame.
    send(32'h7, 1'b1);
    check("single_out_valid", {31'd0, out_valid}, 32'd1);
    check("single_out_count", {28'd0, out_count}, 32'd1);
    check("single_data_0", d[0], 32'h7);
    for (int k = 1; k < 10; k++) check($sformatf("single_pad_%0d", k), d[k], PAD);
    handshake();

    // Back-to-back frames with out_ready tied high.
    for (int i = 0; i < 30; i++) w[i] = $urandom_range(32'h7FFF_FFFF, 0);
    out_ready   = 1'b1;
    ptr         = 0;
    frames      = 0;
    zero_cycles = 0;
    cycles      = 0;
    in_valid    = 1'b1;
    in_last     = 1'b0;
    in_data     = w[0];
    prev_ready  = in_ready;
    while (frames < 3 && cycles < 200) begin
      step();
      cycles++;
      if (prev_ready && ptr < 30) ptr++;
      in_valid = (ptr < 30);
      if (ptr < 30) in_data = w[ptr];
      if (!in_ready) zero_cycles++;
      if (out_valid) begin
        check($sformatf("b2b_count_f%0d", frames), {28'd0, out_count}, 32'd10);
        for (int k = 0; k < 10; k++)
          check($sformatf("b2b_f%0d_data_%0d", frames, k), d[k], w[frames*10 + k]);
        frames++;
      end
      prev_ready = in_ready;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_frames", 32'(frames), 32'd3);
    check("b2b_bubbles", 32'(zero_cycles), 32'd3);
    check("b2b_words", 32'(ptr), 32'd30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
